// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues instruction-memory reads and
// fills the IF/ID register, with stall/flush/redirect handling and a HALT stop.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        halt_in,
    output logic [31:0] instr_out,
    output logic [31:0] npc_out,
    output logic        valid_out,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] npc_q, npc_d;
    logic        valid_q, valid_d;
    logic [31:0] count_q, count_d;
    logic        load;
    logic [31:0] pc_aligned;

    assign pc_aligned = {pc_q[31:2], 2'b00};

    // NOTE: every comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        npc_d   = npc_q;
        valid_d = valid_q;
        count_d = count_q;
        load    = 1'b0;

        if (state_q == FETCH) begin
            load = ihit && !stall && !flush && !redirect;

            if (redirect) begin
                pc_d = {redirect_pc[31:2], 2'b00};
            end else if (load) begin
                pc_d = pc_aligned + 32'd4;
            end

            // Wrong-path squash beats stall; a missed fetch leaves a bubble so
            // decode never sees the same instruction twice.
            if (flush || redirect) begin
                instr_d = '0;
                npc_d   = '0;
                valid_d = 1'b0;
            end else if (load) begin
                instr_d = imemload;
                npc_d   = pc_aligned + 32'd4;
                valid_d = 1'b1;
                count_d = count_q + 32'd1;
            end else if (!stall) begin
                instr_d = '0;
                npc_d   = '0;
                valid_d = 1'b0;
            end

            if (halt_in && valid_q && !flush && !redirect) begin
                state_d = HALTED;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= FETCH;
            pc_q    <= PC_INIT;
            instr_q <= '0;
            npc_q   <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            npc_q   <= npc_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign imemREN     = (state_q == FETCH);
    assign halted      = (state_q == HALTED);
    assign imemaddr    = pc_aligned;
    assign instr_out   = instr_q;
    assign npc_out     = npc_q;
    assign valid_out   = valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage: sequential fetch, stall,
// redirect, flush, bubble, halt, asynchronous reset and 32-bit wrap.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halt_in;

    logic        imemREN,   w_imemREN;
    logic [31:0] imemaddr,  w_imemaddr;
    logic [31:0] instr_out, w_instr_out;
    logic [31:0] npc_out,   w_npc_out;
    logic        valid_out, w_valid_out;
    logic        halted,    w_halted;
    logic [31:0] fetch_count, w_fetch_count;

    int checks   = 0;
    int failures = 0;

    logic [31:0] words [3] = '{32'h2401_0005, 32'h2402_0007, 32'h2403_0009};

    fetch_stage dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(imemREN), .imemaddr(imemaddr), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt_in(halt_in),
        .instr_out(instr_out), .npc_out(npc_out), .valid_out(valid_out),
        .halted(halted), .fetch_count(fetch_count)
    );

    fetch_stage #(.PC_INIT(32'hFFFF_FFFC)) dut_w (
        .CLK(CLK), .RST(RST), .ihit(ihit), .imemload(imemload),
        .imemREN(w_imemREN), .imemaddr(w_imemaddr), .stall(stall), .flush(flush),
        .redirect(redirect), .redirect_pc(redirect_pc), .halt_in(halt_in),
        .instr_out(w_instr_out), .npc_out(w_npc_out), .valid_out(w_valid_out),
        .halted(w_halted), .fetch_count(w_fetch_count)
    );

    always #5 CLK = ~CLK;

    task automatic idle_inputs();
        ihit = 0; imemload = '0; stall = 0; flush = 0;
        redirect = 0; redirect_pc = '0; halt_in = 0;
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        RST = 1;
        cyc();
        RST = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        @(negedge CLK);
        RST = 1;
        #1;
        checks++; if (imemaddr !== 32'h0)   begin failures++; $display("FAIL reset_imemaddr got=%h exp=%h", imemaddr, 32'h0); end
        checks++; if (imemREN !== 1'b1)     begin failures++; $display("FAIL reset_imemREN got=%b exp=1", imemREN); end
        checks++; if (instr_out !== 32'h0)  begin failures++; $display("FAIL reset_instr got=%h exp=0", instr_out); end
        checks++; if (npc_out !== 32'h0)    begin failures++; $display("FAIL reset_npc got=%h exp=0", npc_out); end
        checks++; if (valid_out !== 1'b0)   begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
        checks++; if (halted !== 1'b0)      begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (fetch_count !== 32'h0) begin failures++; $display("FAIL reset_count got=%h exp=0", fetch_count); end
        checks++; if (w_imemaddr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL reset_w_imemaddr got=%h exp=fffffffc", w_imemaddr); end
        cyc();
        RST = 0;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            checks++; if (imemaddr !== 32'(4 * i)) begin failures++; $display("FAIL seq_addr%0d got=%h exp=%h", i, imemaddr, 32'(4 * i)); end
            ihit = 1; imemload = words[i];
            cyc();
            checks++; if (instr_out !== words[i]) begin failures++; $display("FAIL seq_instr%0d got=%h exp=%h", i, instr_out, words[i]); end
            checks++; if (npc_out !== 32'(4 * i + 4)) begin failures++; $display("FAIL seq_npc%0d got=%h exp=%h", i, npc_out, 32'(4 * i + 4)); end
            checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL seq_valid%0d got=%b exp=1", i, valid_out); end
        end
        checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL seq_count got=%0d exp=3", fetch_count); end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            ihit = 1; imemload = words[i];
            cyc();
        end
        stall = 1; ihit = 1; imemload = 32'hDEAD_BEEF;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++; if (imemaddr !== 32'h8) begin failures++; $display("FAIL stall_addr%0d got=%h exp=8", i, imemaddr); end
            checks++; if (instr_out !== words[1]) begin failures++; $display("FAIL stall_instr%0d got=%h exp=%h", i, instr_out, words[1]); end
            checks++; if (npc_out !== 32'h8) begin failures++; $display("FAIL stall_npc%0d got=%h exp=8", i, npc_out); end
            checks++; if (fetch_count !== 32'd2) begin failures++; $display("FAIL stall_count%0d got=%0d exp=2", i, fetch_count); end
            checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL stall_valid%0d got=%b exp=1", i, valid_out); end
        end
        stall = 0; ihit = 1; imemload = words[2];
        cyc();
        checks++; if (instr_out !== words[2]) begin failures++; $display("FAIL unstall_instr got=%h exp=%h", instr_out, words[2]); end
        checks++; if (npc_out !== 32'hC) begin failures++; $display("FAIL unstall_npc got=%h exp=c", npc_out); end
        checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL unstall_count got=%0d exp=3", fetch_count); end
    endtask

    // Continues from test_stall: PC=0xC, count=3, IF/ID valid.
    task automatic test_redirect();
        redirect = 1; redirect_pc = 32'h0000_0103; stall = 1; ihit = 0;
        cyc();
        checks++; if (imemaddr !== 32'h100) begin failures++; $display("FAIL redir_addr got=%h exp=100", imemaddr); end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL redir_valid got=%b exp=0", valid_out); end
        checks++; if (instr_out !== 32'h0) begin failures++; $display("FAIL redir_instr got=%h exp=0", instr_out); end
        checks++; if (npc_out !== 32'h0) begin failures++; $display("FAIL redir_npc got=%h exp=0", npc_out); end
        checks++; if (fetch_count !== 32'd3) begin failures++; $display("FAIL redir_count got=%0d exp=3", fetch_count); end
        redirect = 0; stall = 0; ihit = 1; imemload = 32'hAAAA_0001;
        cyc();
        checks++; if (npc_out !== 32'h104) begin failures++; $display("FAIL redir_target_npc got=%h exp=104", npc_out); end
        checks++; if (instr_out !== 32'hAAAA_0001) begin failures++; $display("FAIL redir_target_instr got=%h exp=aaaa0001", instr_out); end
    endtask

    // PC=0x104, count=4 on entry.
    task automatic test_flush();
        flush = 1; stall = 1; ihit = 1; imemload = 32'hBAD0_0000;
        cyc();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", valid_out); end
        checks++; if (instr_out !== 32'h0) begin failures++; $display("FAIL flush_instr got=%h exp=0", instr_out); end
        checks++; if (imemaddr !== 32'h104) begin failures++; $display("FAIL flush_addr got=%h exp=104", imemaddr); end
        checks++; if (fetch_count !== 32'd4) begin failures++; $display("FAIL flush_count got=%0d exp=4", fetch_count); end
        flush = 0; stall = 0;
    endtask

    task automatic test_bubble();
        ihit = 1; imemload = 32'h1111_1111;
        cyc();
        checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL bubble_pre_valid got=%b exp=1", valid_out); end
        ihit = 0;
        cyc();
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL bubble_valid got=%b exp=0", valid_out); end
        checks++; if (instr_out !== 32'h0) begin failures++; $display("FAIL bubble_instr got=%h exp=0", instr_out); end
        checks++; if (npc_out !== 32'h0) begin failures++; $display("FAIL bubble_npc got=%h exp=0", npc_out); end
        checks++; if (imemaddr !== 32'h108) begin failures++; $display("FAIL bubble_addr got=%h exp=108", imemaddr); end
    endtask

    // PC=0x108, count=5 on entry.
    task automatic test_halt();
        ihit = 1; imemload = 32'h2222_2222;
        cyc();
        halt_in = 1; flush = 1; ihit = 0;
        cyc();
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL halt_flush_halted got=%b exp=0", halted); end
        checks++; if (imemREN !== 1'b1) begin failures++; $display("FAIL halt_flush_ren got=%b exp=1", imemREN); end
        halt_in = 0; flush = 0; ihit = 1; imemload = 32'h3333_3333;
        cyc();
        halt_in = 1; ihit = 0;
        cyc();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_halted got=%b exp=1", halted); end
        checks++; if (imemREN !== 1'b0) begin failures++; $display("FAIL halt_ren got=%b exp=0", imemREN); end
        halt_in = 0; ihit = 1; imemload = 32'h4444_4444;
        for (int i = 0; i < 10; i++) begin
            redirect = (i == 3); redirect_pc = 32'h0000_0800;
            cyc();
            checks++; if (imemaddr !== 32'h110) begin failures++; $display("FAIL halt_addr%0d got=%h exp=110", i, imemaddr); end
            checks++; if (fetch_count !== 32'd7) begin failures++; $display("FAIL halt_count%0d got=%0d exp=7", i, fetch_count); end
            checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_hold%0d got=%b exp=1", i, halted); end
        end
        redirect = 0;
    endtask

    task automatic test_async_reset();
        #2;
        RST = 1;
        #1;
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL arst_halted got=%b exp=0", halted); end
        checks++; if (imemREN !== 1'b1) begin failures++; $display("FAIL arst_ren got=%b exp=1", imemREN); end
        checks++; if (imemaddr !== 32'h0) begin failures++; $display("FAIL arst_addr got=%h exp=0", imemaddr); end
        checks++; if (fetch_count !== 32'h0) begin failures++; $display("FAIL arst_count got=%0d exp=0", fetch_count); end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL arst_valid got=%b exp=0", valid_out); end
        RST = 0;
        idle_inputs();
        ihit = 1; imemload = words[0];
        cyc();
        checks++; if (instr_out !== words[0]) begin failures++; $display("FAIL arst_resume_instr got=%h exp=%h", instr_out, words[0]); end
        checks++; if (npc_out !== 32'h4) begin failures++; $display("FAIL arst_resume_npc got=%h exp=4", npc_out); end
        checks++; if (fetch_count !== 32'd1) begin failures++; $display("FAIL arst_resume_count got=%0d exp=1", fetch_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        ihit = 1; imemload = 32'h5555_5555;
        cyc();
        checks++; if (w_npc_out !== 32'h0) begin failures++; $display("FAIL wrap_npc got=%h exp=0", w_npc_out); end
        checks++; if (w_imemaddr !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%h exp=0", w_imemaddr); end
        ihit = 0;
        force dut.count_d = 32'hFFFF_FFFF;
        cyc();
        release dut.count_d;
        checks++; if (fetch_count !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_preset got=%h exp=ffffffff", fetch_count); end
        ihit = 1; imemload = 32'h6666_6666;
        cyc();
        checks++; if (fetch_count !== 32'h0) begin failures++; $display("FAIL wrap_count got=%h exp=0", fetch_count); end
        cyc();
        checks++; if (fetch_count !== 32'h1) begin failures++; $display("FAIL wrap_count_next got=%h exp=1", fetch_count); end
        ihit = 0;
    endtask

    initial begin
        RST = 0;
        idle_inputs();
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_flush();
        test_bubble();
        test_halt();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter PC_INIT, default 32'h0000_0000: PC value loaded on reset.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST  in  1  asynchronous, active-high reset.
REQ-004 ihit  in  1  instruction memory has returned imemload for the current imemaddr this cycle.
REQ-005 imemload  in  32  fetched instruction word.
REQ-006 imemREN  out  1  instruction read request.
REQ-007 imemaddr  out  32  fetch address (current PC).
REQ-008 stall  in  1  decode cannot accept; hold IF/ID and PC.
REQ-009 flush  in  1  squash IF/ID contents (wrong-path instruction).
REQ-010 redirect  in  1  load PC from redirect_pc (taken branch, J, JAL, JR).
REQ-011 redirect_pc  in  32  target address.
REQ-012 halt_in  in  1  decode of IF/ID instruction is HALT.
REQ-013 instr_out  out  32  IF/ID instruction, drives decoder instruction input.
REQ-014 npc_out  out  32  IF/ID PC+4, used as JAL link value and branch base.
REQ-015 valid_out  out  1  IF/ID holds a real instruction.
REQ-016 halted  out  1  fetch permanently stopped.
REQ-017 fetch_count  out  32  number of instructions loaded into IF/ID since reset.

Function
REQ-018 States: FETCH, HALTED; reset state FETCH.
REQ-019 imemaddr SHALL equal PC with bits [1:0] forced to 0; redirect_pc[1:0] SHALL be ignored.
REQ-020 imemREN SHALL be 1 in FETCH, 0 in HALTED.
REQ-021 In FETCH, IF/ID load condition: ihit=1 and stall=0 and flush=0 and redirect=0; on load, instr_out<=imemload, npc_out<=PC+4, valid_out<=1, fetch_count<=fetch_count+1.
REQ-022 PC update priority in FETCH: redirect=1 -> PC<=redirect_pc (regardless of ihit/stall); else load condition true -> PC<=PC+4; else PC holds.
REQ-023 PC+4 and fetch_count arithmetic SHALL be 32-bit modulo (0xFFFF_FFFC+4 -> 0x0000_0000; count wraps to 0).
REQ-024 flush=1 or redirect=1 SHALL clear IF/ID next edge: instr_out<=0, npc_out<=0, valid_out<=0; flush overrides stall.
REQ-025 stall=1 with flush=0 and redirect=0: IF/ID and PC hold; an ihit that cycle is discarded and refetched later.
REQ-026 ihit=0 with no stall/flush/redirect: PC holds, IF/ID SHALL become a bubble (all-zero, valid_out=0) so the held instruction is not re-executed.
REQ-027 FETCH->HALTED when halt_in=1 and valid_out=1 and flush=0 and redirect=0; halt_in with flush or redirect in the same cycle SHALL be ignored (wrong path).
REQ-028 HALTED: PC, IF/ID, fetch_count frozen; halted=1; all inputs ignored; exit only via RST.
REQ-029 Latency: instruction returned with ihit in cycle N appears on instr_out in cycle N+1.

Reset
REQ-030 RST=1 SHALL immediately (no clock) set PC=PC_INIT, state=FETCH, instr_out=0, npc_out=0, valid_out=0, halted=0, fetch_count=0; imemREN=1, imemaddr=PC_INIT.
REQ-031 RST asserted mid-operation (any state, including pending redirect or HALTED) SHALL discard all state; fetch restarts at PC_INIT on first edge after RST deasserts.

Verification
REQ-032 Reset, ihit=1 every cycle, imemload=0x2401_0005,0x2402_0007,… -> imemaddr 0,4,8; instr_out 0x2401_0005 with npc_out 4 at cycle 1; fetch_count=3 after 3 loads.
REQ-033 stall=1 for 2 cycles at PC=8 with ihit=1 -> imemaddr stays 8, instr_out/npc_out unchanged, fetch_count unchanged; resumes at 8 after stall drops.
REQ-034 redirect=1, redirect_pc=0x0000_0103 with stall=1 and ihit=0 -> next cycle imemaddr=0x0000_0100, valid_out=0, instr_out=0.
REQ-035 halt_in=1 with valid_out=1 -> halted=1, imemREN=0 next cycle, PC and fetch_count frozen for 10 further cycles of ihit=1; halt_in=1 together with flush=1 -> stays FETCH.
REQ-036 PC_INIT=32'hFFFF_FFFC, one ihit -> npc_out=0, imemaddr=0; fetch_count preset near wrap via 2^32 loads not required, check wrap by force.
REQ-037 RST pulsed asynchronously mid-cycle while HALTED -> outputs reach reset values before next edge; fetch from PC_INIT resumes.
